// File: rtl/brick_sprite_fetch_if.sv
// Pixel/bus bundle between the VGA pixel source and the brick sprite fetch block.
interface brick_sprite_fetch_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pix_valid;
  logic [8:0] rom_addr;
  logic [8:0] rom_data;
  logic       brick_kill;
  logic [4:0] kill_col;
  logic [2:0] kill_row;
  logic       level_load;
  logic [8:0] palette_index;
  logic       brick_on;
  logic       out_valid;
  logic       kill_ack;
  logic [7:0] bricks_left;
  logic       all_clear;

  modport master (
    output DrawX, DrawY, pix_valid, rom_data, brick_kill, kill_col, kill_row, level_load,
    input  rom_addr, palette_index, brick_on, out_valid, kill_ack, bricks_left, all_clear
  );

  modport slave (
    input  DrawX, DrawY, pix_valid, rom_data, brick_kill, kill_col, kill_row, level_load,
    output rom_addr, palette_index, brick_on, out_valid, kill_ack, bricks_left, all_clear
  );
endinterface

// File: rtl/brick_sprite_fetch.sv
// Brick wall sprite fetch: 2-stage pixel pipeline against a synchronous sprite ROM,
// plus the alive bitmap with kill / level-load bookkeeping.
module brick_sprite_fetch #(
  parameter logic [9:0] BRICK_Y0 = 10'd32,
  parameter int         N_ROWS   = 8,
  parameter int         N_COLS   = 20
) (
  input logic                 Clk,
  input logic                 Reset_n,
  brick_sprite_fetch_if.slave bus
);
  localparam int          NB     = N_ROWS * N_COLS;
  localparam int          STAGES = 2;
  localparam logic [10:0] Y_END  = 11'(BRICK_Y0) + 11'(16 * N_ROWS);
  localparam logic [10:0] X_END  = 11'(32 * N_COLS);
  localparam logic [NB-1:0] ONE  = NB'(1);
  localparam logic [7:0]  FULL   = 8'(NB);

  logic [NB-1:0]     alive;
  logic [NB-1:0]     pix_sh, kill_sh;
  logic [9:0]        dy;
  logic              in_region;
  logic [2:0]        row;
  logic [4:0]        col;
  logic [7:0]        pix_idx, kill_idx;
  logic              hit_c, hit_q;
  logic              kill_in_range, kill_eff;
  logic [STAGES:1]   vld_pipe;

  // Pixel address decode; everything here is combinational into the ROM.
  assign dy        = bus.DrawY - BRICK_Y0;
  assign in_region = (bus.DrawY >= BRICK_Y0) && ({1'b0, bus.DrawY} < Y_END)
                   && ({1'b0, bus.DrawX} < X_END);
  assign row       = dy[6:4];
  assign col       = bus.DrawX[9:5];
  assign pix_idx   = 8'(row) * 8'(N_COLS) + 8'(col);
  assign bus.rom_addr = in_region ? {dy[3:0], bus.DrawX[4:0]} : 9'd0;

  assign pix_sh = alive >> pix_idx;
  assign hit_c  = bus.pix_valid & in_region & pix_sh[0];

  // Kill target decode; out-of-range indices are gated before they can matter.
  assign kill_idx      = 8'(bus.kill_row) * 8'(N_COLS) + 8'(bus.kill_col);
  assign kill_in_range = (32'(bus.kill_col) < N_COLS) && (32'(bus.kill_row) < N_ROWS);
  assign kill_sh       = alive >> kill_idx;
  assign kill_eff      = bus.brick_kill & kill_in_range & kill_sh[0];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hit_q             <= 1'b0;
      vld_pipe          <= '0;
      bus.palette_index <= 9'd0;
      bus.brick_on      <= 1'b0;
    end else begin
      hit_q             <= hit_c;
      vld_pipe          <= {vld_pipe[STAGES-1:1], bus.pix_valid};
      bus.palette_index <= hit_q ? bus.rom_data : 9'd0;
      bus.brick_on      <= hit_q;
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];

  // The pixel stage reads alive before this edge, so a same-cycle kill only
  // affects the following pixel.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      alive           <= '1;
      bus.bricks_left <= FULL;
      bus.all_clear   <= 1'b0;
      bus.kill_ack    <= 1'b0;
    end else if (bus.level_load) begin
      alive           <= '1;
      bus.bricks_left <= FULL;
      bus.all_clear   <= 1'b0;
      bus.kill_ack    <= 1'b0;
    end else if (kill_eff) begin
      alive           <= alive & ~(ONE << kill_idx);
      bus.bricks_left <= bus.bricks_left - 8'd1;
      bus.all_clear   <= (bus.bricks_left == 8'd1);
      bus.kill_ack    <= 1'b1;
    end else begin
      bus.kill_ack    <= 1'b0;
    end
  end
endmodule

// File: tb/tb_brick_sprite_fetch.sv
// Directed + randomized bench for brick_sprite_fetch against a behavioural wall model.
module tb_brick_sprite_fetch;
  localparam int NR = 8, NC = 20, Y0 = 32;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  brick_sprite_fetch_if bus ();
  brick_sprite_fetch_if b4 ();

  brick_sprite_fetch #(.BRICK_Y0(10'd32), .N_ROWS(8), .N_COLS(20)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  brick_sprite_fetch #(.BRICK_Y0(10'd32), .N_ROWS(4), .N_COLS(20)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(b4));

  // Sprite ROM: 1-cycle latency, content equals its address.
  always @(posedge Clk) bus.rom_data <= bus.rom_addr;
  always @(posedge Clk) b4.rom_data  <= b4.rom_addr;

  int tests = 0, fails = 0;

  typedef struct { bit v; bit on; int pal; } px_t;
  px_t p1, p2, cur;
  bit alive_m [NR][NC];
  int left_m;
  bit ack_m;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_restore();
    for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) alive_m[r][c] = 1'b1;
    left_m = NR * NC;
  endtask

  // One pixel cycle: check the comb ROM address, advance the model, cross the
  // edge, then compare all registered outputs.
  task automatic tick();
    int x, y, ea;
    bit reg_in;
    #1;
    x = int'(bus.DrawX);
    y = int'(bus.DrawY);
    reg_in = (y >= Y0) && (y < Y0 + 16 * NR) && (x < 32 * NC);
    ea = reg_in ? ((y - Y0) % 16) * 32 + (x % 32) : 0;
    chk("rom_addr", 32'(bus.rom_addr), 32'(ea));
    cur.v   = bus.pix_valid;
    cur.on  = bus.pix_valid && reg_in && alive_m[(y - Y0) / 16][x / 32];
    cur.pal = cur.on ? ea : 0;
    p2 = p1;
    p1 = cur;
    if (!Reset_n) begin
      p1 = '{0, 0, 0};
      p2 = '{0, 0, 0};
      model_restore();
      ack_m = 1'b0;
    end else if (bus.level_load) begin
      model_restore();
      ack_m = 1'b0;
    end else if (bus.brick_kill && bus.kill_col < NC && bus.kill_row < NR
                 && alive_m[bus.kill_row][bus.kill_col]) begin
      alive_m[bus.kill_row][bus.kill_col] = 1'b0;
      left_m--;
      ack_m = 1'b1;
    end else begin
      ack_m = 1'b0;
    end
    @(posedge Clk);
    #1;
    chk("out_valid",     32'(bus.out_valid),     32'(p2.v));
    chk("brick_on",      32'(bus.brick_on),      32'(p2.on));
    chk("palette_index", 32'(bus.palette_index), 32'(p2.pal));
    chk("kill_ack",      32'(bus.kill_ack),      32'(ack_m));
    chk("bricks_left",   32'(bus.bricks_left),   32'(left_m));
    chk("all_clear",     32'(bus.all_clear),     32'(left_m == 0));
    bus.brick_kill = 1'b0;
    bus.level_load = 1'b0;
  endtask

  task automatic set_pix(int x, int y, bit v);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.pix_valid = v;
  endtask

  task automatic kill(int c, int r);
    bus.brick_kill = 1'b1;
    bus.kill_col = 5'(c);
    bus.kill_row = 3'(r);
  endtask

  initial begin
    p1 = '{0, 0, 0};
    p2 = '{0, 0, 0};
    ack_m = 1'b0;
    model_restore();
    Reset_n = 1'b0;
    set_pix(0, 0, 0);
    bus.brick_kill = 0; bus.kill_col = 0; bus.kill_row = 0; bus.level_load = 0;
    b4.DrawX = 0; b4.DrawY = 0; b4.pix_valid = 0;
    b4.brick_kill = 0; b4.kill_col = 0; b4.kill_row = 0; b4.level_load = 0;
    tick(); tick();
    Reset_n = 1'b1;
    tick();

    // Basic pixel path and region boundaries
    set_pix(37, 50, 1); tick();
    set_pix(0, 20, 1);  tick();
    set_pix(0, 160, 1); tick();
    set_pix(639, 159, 1); tick();
    set_pix(640, 50, 1); tick();
    set_pix(0, 32, 1);  tick();
    set_pix(0, 0, 0);   tick(); tick();

    // Kill col 3 row 2, then probe it, then repeat the kill
    kill(3, 2); tick();
    set_pix(100, 70, 1); tick();
    set_pix(0, 0, 0); tick(); tick();
    kill(3, 2); tick();
    kill(20, 0); tick();
    kill(31, 7); tick();

    // Row range check on a 4-row wall
    b4.brick_kill = 1; b4.kill_col = 5'd0; b4.kill_row = 3'd7; tick();
    chk("b4_ack_oor",  32'(b4.kill_ack),    32'd0);
    chk("b4_left_oor", 32'(b4.bricks_left), 32'd80);
    b4.kill_col = 5'd19; b4.kill_row = 3'd3; tick();
    chk("b4_ack_ok",   32'(b4.kill_ack),    32'd1);
    chk("b4_left_ok",  32'(b4.bricks_left), 32'd79);
    b4.brick_kill = 0; tick();
    chk("b4_ack_pulse", 32'(b4.kill_ack), 32'd0);

    // Kill the brick being sampled in the same cycle
    set_pix(200, 40, 1); kill(6, 0); tick();
    tick();
    set_pix(0, 0, 0); tick(); tick();

    // Random pixels with random kills and occasional reloads
    for (int i = 0; i < 400; i++) begin
      set_pix($urandom_range(700), $urandom_range(200), 1'($urandom_range(1)));
      if ($urandom_range(3) == 0) kill($urandom_range(23), $urandom_range(7));
      if ($urandom_range(39) == 0) bus.level_load = 1'b1;
      tick();
    end

    // Clear the whole wall, then reload while killing
    set_pix(0, 0, 0);
    bus.level_load = 1'b1; tick();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        kill(c, r); tick();
      end
    set_pix(37, 50, 1); tick();
    kill(0, 0); tick();
    set_pix(0, 0, 0);
    bus.level_load = 1'b1; kill(5, 5); tick();
    tick(); tick();

    // Streaming line sweep with a mid-line reset
    for (int x = 0; x < 640; x++) begin
      set_pix(x, 40 + (x / 80) * 16, 1);
      if (x % 97 == 11) kill(x / 32, (x / 80) % NR);
      Reset_n = (x != 300);
      tick();
    end
    Reset_n = 1'b1;
    set_pix(0, 0, 0); tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/brick_sprite_fetch.md
BRICK_SPRITE_FETCH -- requirements
Module: brick_sprite_fetch

Interface
REQ-001 Parameter BRICK_Y0, default 10'd32, first screen line of the brick wall.
REQ-002 Parameter N_ROWS, default 8, number of brick rows; legal range 1-8.
REQ-003 Parameter N_COLS, default 20, number of brick columns; legal range 1-20.
REQ-004 Clk  in  1  single clock; all state updates on rising edge.
REQ-005 Reset_n  in  1  reset, synchronous, active-low.
REQ-006 DrawX  in  10  current pixel column from the VGA controller.
REQ-007 DrawY  in  10  current pixel row from the VGA controller.
REQ-008 pix_valid  in  1  high when DrawX/DrawY are in the active display area.
REQ-009 rom_addr  out  9  sprite ROM address, combinational; format {local_y[3:0], local_x[4:0]}.
REQ-010 rom_data  in  9  sprite ROM read data; the ROM is synchronous with 1-cycle read latency.
REQ-011 brick_kill  in  1  single-cycle request to destroy one brick.
REQ-012 kill_col  in  5  column of the brick to destroy.
REQ-013 kill_row  in  3  row of the brick to destroy.
REQ-014 level_load  in  1  single-cycle request to restore all bricks.
REQ-015 palette_index  out  9  index to the brick palette, registered.
REQ-016 brick_on  out  1  high when palette_index is a live brick pixel, registered.
REQ-017 out_valid  out  1  pix_valid delayed to align with palette_index.
REQ-018 kill_ack  out  1  one-cycle pulse confirming an effective kill.
REQ-019 bricks_left  out  8  count of live bricks, registered.
REQ-020 all_clear  out  1  high while bricks_left == 0, registered.

Function
REQ-021 Wall region is defined as BRICK_Y0 <= DrawY < BRICK_Y0 + 16*N_ROWS and DrawX < 32*N_COLS; each brick measures 32x16 px.
REQ-022 Within the wall region: col = DrawX[9:5], row = (DrawY - BRICK_Y0)[6:4], local_x = DrawX[4:0], local_y = (DrawY - BRICK_Y0)[3:0].
REQ-023 rom_addr = {local_y, local_x} inside the region and 9'd0 outside; no register in this path.
REQ-024 Stage 1 (edge after inputs) registers hit = pix_valid & in_region & alive[row][col], plus pix_valid.
REQ-025 Stage 2 (next edge) registers palette_index = hit ? rom_data : 9'd0, brick_on = hit, and out_valid = stage-1 pix_valid.
REQ-026 Latency from DrawX/DrawY to palette_index/brick_on/out_valid is exactly 2 cycles; throughput is 1 pixel per cycle, with no stalls.
REQ-027 The alive bitmap holds N_ROWS*N_COLS bits, one per brick.
REQ-028 An effective kill requires brick_kill=1, kill_col < N_COLS, kill_row < N_ROWS, and the target alive.
REQ-029 On an effective kill the next edge clears the target bit, decrements bricks_left by 1, and pulses kill_ack for one cycle.
REQ-030 A kill that is out of range or targets a dead brick changes no state and raises no kill_ack.
REQ-031 level_load=1 sets every alive bit and sets bricks_left = N_ROWS*N_COLS on the next edge; kill_ack stays 0.
REQ-032 level_load and brick_kill asserted in the same cycle: level_load wins and the kill is discarded.
REQ-033 A kill of the brick being sampled in the same cycle takes effect on the next pixel; the current pixel uses the pre-kill bit.
REQ-034 bricks_left never wraps below 0; this holds by construction, because only alive bricks are decremented.
REQ-035 all_clear updates on the same edge as bricks_left and equals (new bricks_left == 0).

Reset
REQ-036 Reset_n=0 at an edge sets all alive bits to 1, bricks_left = N_ROWS*N_COLS (160 at default parameters), all_clear=0, kill_ack=0.
REQ-037 Reset_n=0 at an edge clears all pipeline registers: palette_index=0, brick_on=0, out_valid=0.
REQ-038 Reset has priority over level_load and brick_kill.
REQ-039 Reset asserted mid-frame discards in-flight pixels; the first valid output appears 2 cycles after release.

Verification
REQ-040 Pixel path: DrawX=37, DrawY=50, pix_valid=1, ROM modelled as index=addr -> rom_addr=9'h045; 2 cycles later palette_index=9'h045, brick_on=1, out_valid=1.
REQ-041 Outside region: DrawY=20 or DrawY=160 -> rom_addr=0; 2 cycles later brick_on=0, palette_index=0.
REQ-042 Kill: kill col 3, row 2 -> kill_ack pulses once, bricks_left 160->159; pixel DrawX=100, DrawY=70 then gives brick_on=0; repeating the kill -> no ack, count stays 159.
REQ-043 Out-of-range kill: kill_col=20 or kill_row=7 with N_ROWS=4 -> no state change, no ack.
REQ-044 Clear all 160 bricks -> all_clear=1 on the edge of the last kill; then level_load together with brick_kill -> bricks_left=160, all_clear=0, kill_ack=0.
REQ-045 Streaming plus reset: sweep DrawX 0-639 continuously, checking 2-cycle alignment each cycle; assert Reset_n=0 mid-line -> outputs 0 next edge and bitmap restored.
